hmlf18_min_seq: RTL and testbench
=================================

Name: hmlf18_min_seq

Overview:
- Sequencer that time-shares one 2-input signed MIN comparator (comp2 MIN, HMLF18 flavour) to find the minimum of a WIN-sample window.
- Samples are streamed in over a valid/ready handshake, at most one comparison per cycle.
- Reports the window minimum and the index of its first occurrence over a valid/ready output handshake.
- Sits ahead of the HMLF18 filter stage in the DAC digital path; replaces a comparator tree with one shared comparator.

Parameters:
- WIN, 18, samples per window; legal range 2..32 (elaboration error otherwise).
- W, 7, sample width, signed two's complement.
- IW, 5, index/counter width; must satisfy 2^IW >= WIN.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request to begin a window; honoured only in IDLE, or in DONE in the same cycle as the output handshake.
- Abort  in  1  synchronous abandon of the current window; returns to IDLE.
- In_valid  in  1  In_data valid.
- In_data  in  W  signed sample.
- In_ready  out  1  block accepts a sample this cycle.
- Out_valid  out  1  result valid.
- Out_ready  in  1  downstream accepts the result.
- Out_min  out  W  signed window minimum.
- Out_idx  out  IW  index (0..WIN-1) of the first occurrence of the minimum.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Rst_n=0, asynchronous, any state): state IDLE, accumulator 0, counter 0, Out_valid=0, Out_min=0, Out_idx=0, Busy=0, In_ready=0.
- All outputs come from registers or a decode of the registered state; no combinational path from In_valid to In_ready.
- States: IDLE, FIRST, ACC, DONE.
- IDLE:
  - In_ready=0.
  - Start=1 -> FIRST.
- FIRST:
  - In_ready=1.
  - On accept (In_valid & In_ready): acc<=In_data, idx<=0, cnt<=1, go to ACC.
- ACC:
  - In_ready=1.
  - Comparator wiring: In0=acc, In1=In_data, so a tie keeps acc (the earlier sample).
  - On accept: acc<=comparator output; idx<=cnt only if In_data < acc (strict); cnt<=cnt+1.
  - The accept with cnt==WIN-1 instead loads Out_min/Out_idx from the updated values and goes to DONE.
- Result latency: Out_valid rises the cycle after the WIN-th accepted sample. Cycles without In_valid are stalls and are not counted.
- DONE:
  - Out_valid=1, In_ready=0.
  - Out_min and Out_idx hold stable until Out_valid & Out_ready.
  - On handshake: go to IDLE, or to FIRST if Start=1 in the same cycle. Out_valid falls the next cycle.
- Start outside IDLE/DONE-handshake: ignored; it neither restarts nor extends the window.
- Abort:
  - In FIRST, ACC or DONE: next state IDLE, Out_valid=0; counter and accumulator are cleared; Out_min/Out_idx keep their last values.
  - Abort has priority over Start and over a same-cycle sample accept or output handshake.
  - Abort in IDLE has no effect.
- Arithmetic: the compare is signed over the full W bits (-64 < -1 < 0 < 63). Counter wraps nowhere; it is reset to 0 on entry to FIRST.
- Reset mid-window: all state is lost; the next Start begins a clean window.

Test Plan:
- Window min detection:
  - Stimulus: Start, then 18 back-to-back samples [10,9,8,7,6,-64,5,...,5].
  - Required: Out_min=-64, Out_idx=5, Out_valid high exactly 1 cycle after the 18th accept; Busy high from FIRST through DONE.
- Ties and signed compare:
  - All 18 samples =3 -> Out_min=3, Out_idx=0.
  - Samples with -5 at indices 2 and 11, rest 0 -> Out_idx=2.
  - Window [63,-1,0,...] -> Out_min=-1.
  - Window with -64 last -> Out_min=-64, Out_idx=17.
- Gapped input: In_valid asserted every third cycle.
  - Required: same results as the back-to-back case; result arrives 1 cycle after the 18th accepted sample, not the 18th cycle.
- Output backpressure: Out_ready low for 10 cycles in DONE, with Start pulses and In_valid=1 during that time.
  - Required: Out_min/Out_idx/Out_valid stable, In_ready=0, no new window.
  - Then Out_ready=1 with Start=1 -> state FIRST next cycle, In_ready=1.
- Abort:
  - Abort after 7 samples -> IDLE next cycle, Busy=0, no Out_valid.
  - Abort coincident with the 18th accept -> no result.
  - Next window result is unaffected by the aborted data.
- Asynchronous reset: Rst_n low mid-ACC, between clock edges.
  - Required: Out_valid, Busy, In_ready and Out_min/Out_idx go to 0 immediately, without a clock edge.
  - After release, a full window yields the correct result.

Source files
------------

// File: rtl/hmlf18_min_seq.sv
// hmlf18_min_seq: finds the minimum of a WIN-sample signed window and the index
// of its first occurrence, time-sharing one 2-input signed MIN comparator.
// Samples arrive over valid/ready and at most one sample is compared per cycle.
// The result leaves over a valid/ready handshake.
module hmlf18_min_seq #(
    parameter int WIN = 18,
    parameter int W   = 7,
    parameter int IW  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_min,
    output logic [IW-1:0] out_idx,
    output logic          busy
);

    // Reject illegal parameter sets at elaboration time.
    if ((WIN < 2) || (WIN > 32)) begin : g_bad_win
        $error("hmlf18_min_seq: WIN must be in 2..32");
    end
    if ((2 ** IW) < WIN) begin : g_bad_iw
        $error("hmlf18_min_seq: IW too narrow for WIN");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Shared comparator. A tie returns in0, so the earlier sample is kept.
    function automatic logic [W-1:0] comp2_min(input logic [W-1:0] in0,
                                               input logic [W-1:0] in1);
        logic [W-1:0] res;
        if ($signed(in1) < $signed(in0)) begin
            res = in1;
        end else begin
            res = in0;
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_min_q, out_min_d;
    logic [IW-1:0] out_idx_q, out_idx_d;

    logic [W-1:0]  cmp_min_s;
    logic          cmp_lt_s;
    logic [IW-1:0] idx_upd_s;

    // Comparator datapath: In0 is the accumulator, In1 the incoming sample.
    always_comb begin
        cmp_min_s = comp2_min(acc_q, in_data);
        cmp_lt_s  = ($signed(in_data) < $signed(acc_q));
        if (cmp_lt_s) begin
            idx_upd_s = cnt_q;
        end else begin
            idx_upd_s = idx_q;
        end
    end

    // Next-state and datapath update; abort outranks start, accept and handshake.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        out_min_d = out_min_q;
        out_idx_d = out_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FIRST;
                    cnt_d   = {IW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    acc_d   = {W{1'b0}};
                    idx_d   = {IW{1'b0}};
                    cnt_d   = {IW{1'b0}};
                end else if (in_valid) begin
                    state_d = ST_ACC;
                    acc_d   = in_data;
                    idx_d   = {IW{1'b0}};
                    cnt_d   = IW'(1);
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_ACC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    acc_d   = {W{1'b0}};
                    idx_d   = {IW{1'b0}};
                    cnt_d   = {IW{1'b0}};
                end else if (in_valid) begin
                    acc_d = cmp_min_s;
                    idx_d = idx_upd_s;
                    if (cnt_q == IW'(WIN - 1)) begin
                        // Last sample of the window: publish the result.
                        state_d   = ST_DONE;
                        out_min_d = cmp_min_s;
                        out_idx_d = idx_upd_s;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    acc_d   = {W{1'b0}};
                    idx_d   = {IW{1'b0}};
                    cnt_d   = {IW{1'b0}};
                end else if (out_ready) begin
                    if (start) begin
                        state_d = ST_FIRST;
                        cnt_d   = {IW{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= {W{1'b0}};
            idx_q     <= {IW{1'b0}};
            cnt_q     <= {IW{1'b0}};
            out_min_q <= {W{1'b0}};
            out_idx_q <= {IW{1'b0}};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            out_min_q <= out_min_d;
            out_idx_q <= out_idx_d;
        end
    end

    // Handshake and status outputs are pure decodes of the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
            ST_FIRST, ST_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign out_min = out_min_q;
    assign out_idx = out_idx_q;

endmodule

// File: tb/tb_hmlf18_min_seq.sv
// Bench for hmlf18_min_seq: table of windows with hand-derived results, a
// scoreboard queue filled when a window starts and drained at each output
// handshake, plus hand sequences for backpressure, abort and async reset.
module tb_hmlf18_min_seq;

    localparam int WIN = 18;
    localparam int W   = 7;
    localparam int IW  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  out_min;
    logic [IW-1:0] out_idx;

    hmlf18_min_seq #(.WIN(WIN), .W(W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
        .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                  name;
        logic [WIN-1:0][W-1:0]  s;
        int                     gap;
        int                     emin;
        int                     eidx;
    } vec_t;

    typedef struct {
        int mn;
        int ix;
    } res_t;

    vec_t vecs[7];
    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   last_min = 0;
    int   last_idx = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Independent reference: strict less-than keeps the first occurrence.
    function automatic void model(input vec_t v, output int mn, output int ix);
        mn = $signed(v.s[0]);
        ix = 0;
        for (int k = 1; k < WIN; k++) begin
            if (int'($signed(v.s[k])) < mn) begin
                mn = $signed(v.s[k]);
                ix = k;
            end
        end
    endfunction

    // Scoreboard consumer: one result per output handshake.
    always @(negedge clk) begin : mon
        res_t r;
        if (rst_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                r = exp_q.pop_front();
                chk("sb_min", $signed(out_min), r.mn);
                chk("sb_idx", int'(out_idx), r.ix);
                last_min = r.mn;
                last_idx = r.ix;
            end
        end
    end

    // Feed n_feed samples; optionally abort on the last one.
    task automatic run_window(input vec_t v, input int n_feed, input bit abort_last,
                              input bit do_start, input bit push);
        res_t r;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (push) begin
            r.mn = v.emin;
            r.ix = v.eidx;
            exp_q.push_back(r);
        end
        chk({v.name, "_first_rdy"}, in_ready, 1);
        chk({v.name, "_first_busy"}, busy, 1);
        for (int k = 0; k < n_feed; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                start    = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk({v.name, "_gap_busy"}, busy, 1);
            end
            in_valid = 1'b1;
            in_data  = v.s[k];
            abort    = (abort_last && (k == n_feed - 1)) ? 1'b1 : 1'b0;
            chk({v.name, "_early_ovalid"}, out_valid, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            abort    = 1'b0;
        end
        if (abort_last) begin
            chk({v.name, "_abort_busy"}, busy, 0);
            chk({v.name, "_abort_ovalid"}, out_valid, 0);
            chk({v.name, "_abort_rdy"}, in_ready, 0);
        end else if (n_feed == WIN) begin
            chk({v.name, "_latency_ovalid"}, out_valid, 1);
            chk({v.name, "_done_rdy"}, in_ready, 0);
            chk({v.name, "_done_busy"}, busy, 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_ovalid_seen", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_ovalid_fall", out_valid, 0);
        chk("drain_busy_idle", busy, 0);
    endtask

    initial begin
        int tmp;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;

        // Build the vector table.
        foreach (vecs[i]) begin
            vecs[i].gap = 0;
        end
        vecs[0].name = "bb_min";   vecs[0].emin = -64; vecs[0].eidx = 5;
        vecs[1].name = "all3";     vecs[1].emin = 3;   vecs[1].eidx = 0;
        vecs[2].name = "tie_m5";   vecs[2].emin = -5;  vecs[2].eidx = 2;
        vecs[3].name = "signed";   vecs[3].emin = -1;  vecs[3].eidx = 1;
        vecs[4].name = "last_min"; vecs[4].emin = -64; vecs[4].eidx = 17;
        vecs[5].name = "gapped";   vecs[5].emin = -64; vecs[5].eidx = 5;
        vecs[5].gap = 2;
        vecs[6].name = "random";   vecs[6].gap = 1;
        for (int k = 0; k < WIN; k++) begin
            tmp = (k < 5) ? (10 - k) : ((k == 5) ? -64 : 5);
            vecs[0].s[k] = 7'(tmp);
            vecs[5].s[k] = 7'(tmp);
            vecs[1].s[k] = 7'd3;
            tmp = ((k == 2) || (k == 11)) ? -5 : 0;
            vecs[2].s[k] = 7'(tmp);
            tmp = (k == 0) ? 63 : ((k == 1) ? -1 : 0);
            vecs[3].s[k] = 7'(tmp);
            tmp = (k == WIN - 1) ? -64 : 20;
            vecs[4].s[k] = 7'(tmp);
            vecs[6].s[k] = 7'($urandom_range(127, 0));
        end
        model(vecs[6], vecs[6].emin, vecs[6].eidx);

        // Reset state, checked before and after release between edges.
        #12;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_min", int'(out_min), 0);
        chk("rst_idx", int'(out_idx), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_rdy", in_ready, 0);

        // Table-driven windows.
        for (int i = 0; i < 7; i++) begin
            run_window(vecs[i], WIN, 1'b0, 1'b1, 1'b1);
            drain();
        end

        // Backpressure in DONE with stray start and in_valid.
        run_window(vecs[3], WIN, 1'b0, 1'b1, 1'b1);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            start    = (c % 2 == 0) ? 1'b1 : 1'b0;
            in_valid = 1'b1;
            in_data  = 7'h40;
            @(posedge clk); #1;
            chk("bp_ovalid", out_valid, 1);
            chk("bp_rdy", in_ready, 0);
            chk("bp_min", $signed(out_min), -1);
            chk("bp_idx", int'(out_idx), 1);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("bp_restart_ovalid", out_valid, 0);
        chk("bp_restart_rdy", in_ready, 1);
        chk("bp_restart_busy", busy, 1);
        run_window(vecs[0], WIN, 1'b0, 1'b0, 1'b1);
        drain();

        // Abort after 7 samples, then idle for a few cycles.
        run_window(vecs[4], 8, 1'b1, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort7_quiet", out_valid, 0);
        end
        // Abort coincident with the 18th accept: no result, outputs kept.
        run_window(vecs[4], WIN, 1'b1, 1'b1, 1'b0);
        chk("abort18_min_kept", $signed(out_min), last_min);
        chk("abort18_idx_kept", int'(out_idx), last_idx);
        // Following window is clean.
        run_window(vecs[2], WIN, 1'b0, 1'b1, 1'b1);
        drain();

        // Asynchronous reset mid-ACC, between clock edges.
        run_window(vecs[0], 9, 1'b0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ovalid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_min", int'(out_min), 0);
        chk("arst_idx", int'(out_idx), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(vecs[6], WIN, 1'b0, 1'b1, 1'b1);
        drain();

        chk("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
